// File: rtl/seq_mul_unit_if.sv
// Request/response bundle between the datapath MULT/MULTU issue logic and the multiplier.
// Latency: none (wiring only).
// Backpressure: requester must watch busy; a start raised while busy is dropped, not queued.
// Signals:
//   start, is_signed, data_a, data_b : request side, driven by the master
//   busy, done, product, hi, lo      : status and result, driven by the slave
interface seq_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     data_a;
  logic [WIDTH-1:0]     data_b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  modport master (
    output start, is_signed, data_a, data_b,
    input  busy, done, product, hi, lo
  );

  modport slave (
    input  start, is_signed, data_a, data_b,
    output busy, done, product, hi, lo
  );
endinterface

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier (one multiplier bit per clock), signed/unsigned, HI/LO outputs.
// Latency: start edge N -> done high in the cycle after edge N+WIDTH (WIDTH RUN cycles + 1 DONE).
// Backpressure: busy high in RUN/DONE; start is ignored while busy and never queued.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : seq_mul_unit_if.slave (start/is_signed/data_a/data_b in; busy/done/product/hi/lo out)
// Build option: define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are zero.
module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  seq_mul_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcnd;
  logic [WIDTH-1:0]     mpr;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mpr_next;
  logic                 last;

  // Operands are multiplied as magnitudes; the sign is applied once at the end.
  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
  always_comb begin
    mag_a = bus.data_a;
    mag_b = bus.data_b;
    if (bus.is_signed && bus.data_a[WIDTH-1]) mag_a = -bus.data_a;
    if (bus.is_signed && bus.data_b[WIDTH-1]) mag_b = -bus.data_b;
  end

  always_comb begin
    acc_next = acc;
    if (mpr[0]) acc_next = acc + mcnd;
    mpr_next = mpr >> 1;
`ifdef MUL_EARLY_TERM_EN
    // Remaining multiplier bits all zero: further iterations add nothing.
    last = (mpr_next == '0);
`else
    // cnt counts completed iterations; this edge is iteration number WIDTH.
    last = (cnt == CNT_W'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc       <= '0;
      mcnd      <= '0;
      mpr       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc  <= '0;
            mcnd <= {{WIDTH{1'b0}}, mag_a};
            mpr  <= mag_b;
            cnt  <= '0;
            neg  <= bus.is_signed & (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]);
          end
        end
        RUN: begin
          acc  <= acc_next;
          mcnd <= mcnd << 1;
          mpr  <= mpr_next;
          cnt  <= cnt + CNT_W'(1);
          if (last) product_q <= neg ? -acc_next : acc_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
  assign bus.hi      = product_q[2*WIDTH-1:WIDTH];
  assign bus.lo      = product_q[WIDTH-1:0];
endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed bench for seq_mul_unit with hand-computed products, latency and busy checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_mul_unit;
  localparam int W = 32;
`ifdef MUL_EARLY_TERM_EN
  localparam int PULSE_AT = 2;
  localparam int RST_AT   = 2;
`else
  localparam int PULSE_AT = 5;
  localparam int RST_AT   = 10;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   lat;
  int   bcnt;
  int   dcnt;

  seq_mul_unit_if #(.WIDTH(W)) u_if ();

  seq_mul_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done; lat = negedge index of done after the start edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int l, output int bc);
    @(negedge clk);
    u_if.start = 1'b1; u_if.data_a = a; u_if.data_b = b; u_if.is_signed = s;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    l = -1; bc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (u_if.busy) bc++;
      if (u_if.done) begin l = i; break; end
    end
    if (l < 0) chk("done_timeout", 64'(l), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    u_if.start = 1'b0; u_if.is_signed = 1'b0; u_if.data_a = '0; u_if.data_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(u_if.busy), 64'd0);
    chk("rst_done", 64'(u_if.done), 64'd0);
    chk("rst_product", u_if.product, 64'd0);
    reset = 1'b0;

    // 1: unsigned 3*5
    do_op(32'd3, 32'd5, 1'b0, lat, bcnt);
    chk("u3x5_product", u_if.product, 64'hF);
    chk("u3x5_hi", 64'(u_if.hi), 64'd0);
    chk("u3x5_lo", 64'(u_if.lo), 64'd15);
`ifndef MUL_EARLY_TERM_EN
    chk("u3x5_latency", 64'(lat), 64'd33);
    chk("u3x5_busy_cycles", 64'(bcnt), 64'd33);
`else
    chk("et3x5_latency", 64'(lat), 64'd4);
    chk("et3x5_busy_cycles", 64'(bcnt), 64'd4);
`endif
    @(negedge clk);
    chk("u3x5_done_one_cycle", 64'(u_if.done), 64'd0);
    chk("u3x5_idle_busy", 64'(u_if.busy), 64'd0);
    chk("u3x5_product_hold", u_if.product, 64'hF);

    // 2: signed / unsigned interpretation of the same bits
    do_op(32'hFFFFFFFE, 32'h3, 1'b1, lat, bcnt);
    chk("s_m2x3", u_if.product, 64'hFFFFFFFFFFFFFFFA);
    chk("s_m2x3_hi", 64'(u_if.hi), 64'hFFFFFFFF);
    do_op(32'hFFFFFFFE, 32'h3, 1'b0, lat, bcnt);
    chk("u_m2x3", u_if.product, 64'h00000002FFFFFFFA);
    do_op(32'd5, 32'hFFFFFFFC, 1'b1, lat, bcnt);
    chk("s_5xm4", u_if.product, 64'hFFFFFFFFFFFFFFEC);
    do_op(32'd0, 32'hFFFFFFFB, 1'b1, lat, bcnt);
    chk("s_0xm5", u_if.product, 64'd0);

    // 3: extremes
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bcnt);
    chk("u_max_sq", u_if.product, 64'hFFFFFFFE00000001);
    do_op(32'h80000000, 32'h80000000, 1'b1, lat, bcnt);
    chk("s_min_sq", u_if.product, 64'h4000000000000000);
    do_op(32'h80000000, 32'h1, 1'b1, lat, bcnt);
    chk("s_min_x1", u_if.product, 64'hFFFFFFFF80000000);
    chk("s_min_x1_lo", 64'(u_if.lo), 64'h80000000);
`ifndef MUL_EARLY_TERM_EN
    chk("s_min_x1_latency", 64'(lat), 64'd33);
`endif

    // 4: start while busy is ignored; reset mid-operation discards the result
    @(negedge clk);
    u_if.start = 1'b1; u_if.data_a = 32'd7; u_if.data_b = 32'd9; u_if.is_signed = 1'b0;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == PULSE_AT) begin
        u_if.start = 1'b1; u_if.data_a = 32'd1; u_if.data_b = 32'd1;
      end else begin
        u_if.start = 1'b0;
      end
      if (u_if.done) begin lat = i; break; end
    end
    u_if.start = 1'b0;
    chk("busy_start_ignored", u_if.product, 64'd63);
`ifndef MUL_EARLY_TERM_EN
    chk("busy_start_latency", 64'(lat), 64'd33);
`endif
    @(negedge clk);
    chk("busy_start_not_queued", 64'(u_if.busy), 64'd0);

    u_if.start = 1'b1; u_if.data_a = 32'd6; u_if.data_b = 32'd6;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    for (int i = 1; i <= RST_AT; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midop_rst_busy", 64'(u_if.busy), 64'd0);
    chk("midop_rst_done", 64'(u_if.done), 64'd0);
    chk("midop_rst_product", u_if.product, 64'd0);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.done) dcnt++;
    end
    chk("midop_rst_no_done", 64'(dcnt), 64'd0);

    // 5: back-to-back, second start raised during the done cycle
    do_op(32'd2, 32'd2, 1'b0, lat, bcnt);
    chk("b2b_first", u_if.product, 64'd4);
    u_if.start = 1'b1; u_if.data_a = 32'd10; u_if.data_b = 32'd10;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 2) u_if.start = 1'b0;
      if (u_if.done) begin lat = i; break; end
    end
    u_if.start = 1'b0;
    chk("b2b_second", u_if.product, 64'd100);
`ifndef MUL_EARLY_TERM_EN
    chk("b2b_gap", 64'(lat), 64'd34);
`endif

`ifdef MUL_EARLY_TERM_EN
    // 6: early termination lengths
    do_op(32'd7, 32'd0, 1'b0, lat, bcnt);
    chk("et7x0_product", u_if.product, 64'd0);
    chk("et7x0_latency", 64'(lat), 64'd2);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, bcnt);
    chk("et_m1xm1_product", u_if.product, 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
